mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 The block SHALL have ports `clk`  in  1  and `rst`  in  1; a single clock, rising edge only; `rst` is a synchronous, active-low reset (0 = reset asserted).
REQ-002 The block SHALL have port `stall_mem`  in  1: the MEM stage is stalled this cycle.
REQ-003 The block SHALL have port `stall_wb`  in  1: the WB stage is stalled, so hold the current outputs.
REQ-004 The block SHALL have port `flush`  in  1: discard the in-flight instruction.
REQ-005 The block SHALL have port `mem_valid`  in  1: the MEM stage presents a real instruction.
REQ-006 The block SHALL have port `mem_we`  in  1: the instruction writes a GPR.
REQ-007 The block SHALL have port `mem_waddr`  in  5: destination GPR.
REQ-008 The block SHALL have port `mem_wdata`  in  32: ALU result, used for non-loads.
REQ-009 The block SHALL have port `mem_ld_op`  in  3: 000 none, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LW; 110 and 111 are treated as none.
REQ-010 The block SHALL have port `mem_addr_lo`  in  2: byte offset of the load address.
REQ-011 The block SHALL have port `mem_rdata`  in  32: raw big-endian memory word, where offset 0 is bits 31:24.
REQ-012 The block SHALL have port `wb_we`  out  1: registered; drives the register-file write enable.
REQ-013 The block SHALL have port `wb_waddr`  out  5: registered; drives the register-file write address.
REQ-014 The block SHALL have port `wb_wdata`  out  32: registered; drives the register-file write data.
REQ-015 The block SHALL have port `wb_excp_ade`  out  1: registered single-cycle flag for an address-error load.
REQ-016 The block SHALL have port `wb_retire_cnt`  out  32: registered count of retired instructions.

Function
REQ-017 Latency SHALL be one cycle: inputs sampled at edge N appear on the wb_* outputs after edge N.
REQ-018 Update priority at each edge SHALL be: reset, then flush, then stall_wb (hold), then stall_mem (bubble), then capture.
REQ-019 On flush=1, the block SHALL load a bubble regardless of both stall inputs.
- Bubble: wb_we=0, wb_waddr=0, wb_wdata=0, wb_excp_ade=0; counter unchanged.
REQ-020 On stall_wb=1 with flush=0, the block SHALL hold all outputs, including wb_retire_cnt.
- wb_excp_ade is held, not cleared.
REQ-021 On stall_mem=1, stall_wb=0, flush=0, the block SHALL load a bubble.
REQ-022 On capture with mem_valid=0, the block SHALL load a bubble.
REQ-023 On capture with mem_valid=1, the block SHALL load wb_waddr=mem_waddr and wb_wdata as follows.
- mem_ld_op none: wb_wdata=mem_wdata.
- LB/LBU: selected byte (offset 0 → bits 31:24 … offset 3 → bits 7:0), sign-extended (LB) or zero-extended (LBU) to 32 bits.
- LH/LHU: offset 0 → bits 31:16, offset 2 → bits 15:0, sign-extended (LH) or zero-extended (LHU).
- LW: the full word.
REQ-024 A misaligned load (LH/LHU with mem_addr_lo[0]=1, or LW with mem_addr_lo≠0) SHALL produce wb_excp_ade=1, wb_we=0, wb_wdata=0; wb_waddr is still loaded.
REQ-025 wb_we on a valid capture SHALL equal mem_we, forced to 0 when mem_waddr=0 or the load is misaligned.
REQ-026 wb_excp_ade SHALL be 0 on every capture that is not a misaligned load, so it lasts one cycle unless held by stall_wb.
REQ-027 wb_retire_cnt SHALL increment by 1 on each valid capture, including misaligned loads and writes to r0, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-028 A bubble and a hold SHALL never change wb_retire_cnt.
REQ-029 All outputs SHALL come directly from flops; there is no combinational path from inputs to outputs.

Reset
REQ-030 While rst=0 at a rising edge, all outputs SHALL become 0, including wb_retire_cnt, regardless of all other inputs.
REQ-031 Reset asserted while a stall is held SHALL discard the held instruction.
REQ-032 The first capture after rst returns to 1 SHALL occur at the next edge.
REQ-033 No output SHALL change between edges.

Verification
REQ-034 The bench SHALL cover: reset, then valid, mem_we=1, waddr=5, wdata=0x12345678, ld_op=000 → next cycle wb_we=1, wb_waddr=5, wb_wdata=0x12345678, cnt=1.
REQ-035 The bench SHALL cover byte loads with mem_rdata=0x80FF7F01.
- LB off=0 → 0xFFFFFF80.
- LBU off=1 → 0x000000FF.
- LB off=2 → 0x0000007F.
- LH off=0 → 0xFFFF80FF.
- LHU off=2 → 0x00007F01.
REQ-036 The bench SHALL cover LW with off=2 and waddr=9 → wb_we=0, wb_excp_ade=1 for exactly one cycle, cnt incremented; next capture clears wb_excp_ade.
REQ-037 The bench SHALL cover stall and flush.
- stall_wb=1 for 3 cycles after a capture → outputs and cnt unchanged.
- stall_mem=1, stall_wb=0 → wb_we=0 bubble.
- flush=1 together with stall_wb=1 → bubble.
REQ-038 The bench SHALL cover mem_we=1, waddr=0, wdata=0xDEADBEEF → wb_we=0, cnt incremented.
REQ-039 The bench SHALL cover a counter forced to 0xFFFFFFFF plus one valid capture → cnt=0.
REQ-040 The bench SHALL cover rst=0 mid-stall → all outputs 0 at the next edge.

Source files
------------

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//
// Purpose:
//   MEM/WB pipeline register for a 5-stage in-order core. It registers the
//   result of the MEM stage for the register-file write port. For loads it
//   extracts the addressed byte, halfword or word from the big-endian memory
//   word and sign- or zero-extends it. It flags misaligned loads as address
//   errors and keeps a count of retired instructions.
//
// Ports:
//   clk            in   1   clock, rising edge active
//   rst            in   1   synchronous reset, active-low (0 = reset)
//   stall_mem      in   1   MEM stage stalled: insert a bubble
//   stall_wb       in   1   WB stage stalled: hold every output
//   flush          in   1   discard the in-flight instruction (bubble)
//   mem_valid      in   1   MEM presents a real instruction
//   mem_we         in   1   instruction writes a GPR
//   mem_waddr      in   5   destination GPR
//   mem_wdata      in  32   ALU result for non-loads
//   mem_ld_op      in   3   000 none, 001 LB, 010 LBU, 011 LH, 100 LHU,
//                           101 LW, 110/111 none
//   mem_addr_lo    in   2   byte offset of the load address
//   mem_rdata      in  32   raw memory word, offset 0 = bits 31:24
//   wb_we          out  1   register-file write enable
//   wb_waddr       out  5   register-file write address
//   wb_wdata       out 32   register-file write data
//   wb_excp_ade    out  1   address-error load flag (one cycle unless held)
//   wb_retire_cnt  out 32   retired-instruction count, wraps at 2^32
//
// Every output comes straight from a flop. The update priority is reset,
// then flush, then stall_wb, then stall_mem, then capture.
// -----------------------------------------------------------------------------
module mem_wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_mem,
  input  logic        stall_wb,
  input  logic        flush,
  input  logic        mem_valid,
  input  logic        mem_we,
  input  logic [4:0]  mem_waddr,
  input  logic [31:0] mem_wdata,
  input  logic [2:0]  mem_ld_op,
  input  logic [1:0]  mem_addr_lo,
  input  logic [31:0] mem_rdata,
  output logic        wb_we,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_wdata,
  output logic        wb_excp_ade,
  output logic [31:0] wb_retire_cnt
);

  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_LB   = 3'b001;
  localparam logic [2:0] LD_LBU  = 3'b010;
  localparam logic [2:0] LD_LH   = 3'b011;
  localparam logic [2:0] LD_LHU  = 3'b100;
  localparam logic [2:0] LD_LW   = 3'b101;

  // State registers and their next-state values
  logic        we_q,    we_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ade_q,   ade_d;
  logic [31:0] cnt_q,   cnt_d;

  // Byte lane for a given offset; the memory word is big-endian.
  function automatic logic [7:0] pick_byte(input logic [31:0] word,
                                           input logic [1:0]  off);
    logic [7:0] b;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

  // Only offsets 0 and 2 are legal for halfwords. Bit 0 is checked elsewhere,
  // so only bit 1 selects the half here.
  function automatic logic [15:0] pick_half(input logic [31:0] word,
                                            input logic [1:0]  off);
    return off[1] ? word[15:0] : word[31:16];
  endfunction

  function automatic logic is_misaligned(input logic [2:0] op,
                                         input logic [1:0] off);
    logic m;
    case (op)
      LD_LH, LD_LHU: m = off[0];
      LD_LW:         m = (off != 2'd0);
      default:       m = 1'b0;
    endcase
    return m;
  endfunction

  // Write-back value for an aligned instruction. Opcodes 110/111 behave like
  // "none" and pass the ALU result through.
  function automatic logic [31:0] load_result(input logic [2:0]  op,
                                              input logic [1:0]  off,
                                              input logic [31:0] rdata,
                                              input logic [31:0] alu);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = pick_byte(rdata, off);
    h = pick_half(rdata, off);
    case (op)
      LD_LB:   r = {{24{b[7]}}, b};
      LD_LBU:  r = {24'd0, b};
      LD_LH:   r = {{16{h[15]}}, h};
      LD_LHU:  r = {16'd0, h};
      LD_LW:   r = rdata;
      default: r = alu;
    endcase
    return r;
  endfunction

  logic misaligned;
  assign misaligned = is_misaligned(mem_ld_op, mem_addr_lo);

  always_comb begin
    we_d    = we_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    ade_d   = ade_q;
    cnt_d   = cnt_q;
    if (flush || (!stall_wb && (stall_mem || !mem_valid))) begin
      // Bubble: clear the payload and leave the counter alone.
      we_d    = 1'b0;
      waddr_d = 5'd0;
      wdata_d = 32'd0;
      ade_d   = 1'b0;
    end else if (!stall_wb) begin
      // Valid capture. It retires even when it is misaligned or targets r0.
      waddr_d = mem_waddr;
      cnt_d   = cnt_q + 32'd1;
      if (misaligned) begin
        we_d    = 1'b0;
        wdata_d = 32'd0;
        ade_d   = 1'b1;
      end else begin
        we_d    = mem_we && (mem_waddr != 5'd0);
        wdata_d = load_result(mem_ld_op, mem_addr_lo, mem_rdata, mem_wdata);
        ade_d   = 1'b0;
      end
    end
    // Otherwise stall_wb holds every register, including the ADE flag.
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      we_q    <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= 32'd0;
      ade_q   <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      ade_q   <= ade_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wb_we         = we_q;
  assign wb_waddr      = waddr_q;
  assign wb_wdata      = wdata_q;
  assign wb_excp_ade   = ade_q;
  assign wb_retire_cnt = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_stage
//
// Directed bench for mem_wb_stage. Inputs are driven with blocking assignments
// while the clock is away from its rising edge. Outputs are sampled 1 time
// unit after each rising edge. Every expected value is a hand-computed
// constant.
// -----------------------------------------------------------------------------
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_mem;
  logic        stall_wb;
  logic        flush;
  logic        mem_valid;
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_ld_op;
  logic [1:0]  mem_addr_lo;
  logic [31:0] mem_rdata;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        wb_excp_ade;
  logic [31:0] wb_retire_cnt;

  int passed = 0;
  int total  = 0;

  mem_wb_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall_mem     (stall_mem),
    .stall_wb      (stall_wb),
    .flush         (flush),
    .mem_valid     (mem_valid),
    .mem_we        (mem_we),
    .mem_waddr     (mem_waddr),
    .mem_wdata     (mem_wdata),
    .mem_ld_op     (mem_ld_op),
    .mem_addr_lo   (mem_addr_lo),
    .mem_rdata     (mem_rdata),
    .wb_we         (wb_we),
    .wb_waddr      (wb_waddr),
    .wb_wdata      (wb_wdata),
    .wb_excp_ade   (wb_excp_ade),
    .wb_retire_cnt (wb_retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic ade,
                         input logic [31:0] cnt);
    chk({tag, ".we"},  {31'd0, wb_we},       {31'd0, we});
    chk({tag, ".wa"},  {27'd0, wb_waddr},    {27'd0, wa});
    chk({tag, ".wd"},  wb_wdata,             wd);
    chk({tag, ".ade"}, {31'd0, wb_excp_ade}, {31'd0, ade});
    chk({tag, ".cnt"}, wb_retire_cnt,        cnt);
  endtask

  // Advance one rising edge, then settle before the outputs are sampled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [2:0] op,
                       input logic [1:0] off);
    mem_valid   = v;
    mem_we      = we;
    mem_waddr   = wa;
    mem_wdata   = wd;
    mem_ld_op   = op;
    mem_addr_lo = off;
  endtask

  initial begin
    rst = 1'b0; stall_mem = 1'b0; stall_wb = 1'b0; flush = 1'b0;
    mem_rdata = 32'h80FF7F01;
    // Reset with a live instruction on the inputs: it must not be captured.
    drive(1'b1, 1'b1, 5'd3, 32'hCAFEF00D, 3'b000, 2'd0);
    step(); step();
    chk_all("reset", 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);

    // Plain ALU write, captured at the first edge after reset is released.
    rst = 1'b1;
    drive(1'b1, 1'b1, 5'd5, 32'h12345678, 3'b000, 2'd0);
    step();
    chk_all("alu", 1'b1, 5'd5, 32'h12345678, 1'b0, 32'd1);

    // Loads from memory word 0x80FF7F01.
    drive(1'b1, 1'b1, 5'd6, 32'h0, 3'b001, 2'd0); step();
    chk_all("lb0",   1'b1, 5'd6, 32'hFFFFFF80, 1'b0, 32'd2);
    drive(1'b1, 1'b1, 5'd6, 32'h0, 3'b010, 2'd1); step();
    chk_all("lbu1",  1'b1, 5'd6, 32'h000000FF, 1'b0, 32'd3);
    drive(1'b1, 1'b1, 5'd6, 32'h0, 3'b001, 2'd2); step();
    chk_all("lb2",   1'b1, 5'd6, 32'h0000007F, 1'b0, 32'd4);
    drive(1'b1, 1'b1, 5'd6, 32'h0, 3'b010, 2'd3); step();
    chk_all("lbu3",  1'b1, 5'd6, 32'h00000001, 1'b0, 32'd5);
    drive(1'b1, 1'b1, 5'd6, 32'h0, 3'b011, 2'd0); step();
    chk_all("lh0",   1'b1, 5'd6, 32'hFFFF80FF, 1'b0, 32'd6);
    drive(1'b1, 1'b1, 5'd6, 32'h0, 3'b100, 2'd2); step();
    chk_all("lhu2",  1'b1, 5'd6, 32'h00007F01, 1'b0, 32'd7);
    drive(1'b1, 1'b1, 5'd6, 32'h0, 3'b101, 2'd0); step();
    chk_all("lw0",   1'b1, 5'd6, 32'h80FF7F01, 1'b0, 32'd8);
    drive(1'b1, 1'b1, 5'd6, 32'hA5A5A5A5, 3'b110, 2'd1); step();
    chk_all("op110", 1'b1, 5'd6, 32'hA5A5A5A5, 1'b0, 32'd9);
    drive(1'b1, 1'b0, 5'd4, 32'h33333333, 3'b000, 2'd0); step();
    chk_all("we0",   1'b0, 5'd4, 32'h33333333, 1'b0, 32'd10);

    // A misaligned LW raises ADE for one cycle; the next capture clears it.
    drive(1'b1, 1'b1, 5'd9, 32'h0, 3'b101, 2'd2); step();
    chk_all("lw_ade", 1'b0, 5'd9, 32'd0, 1'b1, 32'd11);
    drive(1'b1, 1'b1, 5'd7, 32'h11111111, 3'b000, 2'd0); step();
    chk_all("ade_clr", 1'b1, 5'd7, 32'h11111111, 1'b0, 32'd12);

    // stall_wb for 3 cycles while other input values are presented.
    stall_wb = 1'b1;
    drive(1'b1, 1'b1, 5'd2, 32'h44444444, 3'b000, 2'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("hold", 1'b1, 5'd7, 32'h11111111, 1'b0, 32'd12);
    end
    stall_wb = 1'b0;

    // A misaligned LH keeps its ADE flag while stall_wb holds it.
    drive(1'b1, 1'b1, 5'd3, 32'h0, 3'b011, 2'd1); step();
    chk_all("lh_ade", 1'b0, 5'd3, 32'd0, 1'b1, 32'd13);
    stall_wb = 1'b1; step();
    chk_all("ade_hold", 1'b0, 5'd3, 32'd0, 1'b1, 32'd13);
    stall_wb = 1'b0;

    // stall_mem alone gives a bubble.
    stall_mem = 1'b1;
    drive(1'b1, 1'b1, 5'd8, 32'h55555555, 3'b000, 2'd0); step();
    chk_all("stall_mem", 1'b0, 5'd0, 32'd0, 1'b0, 32'd13);
    stall_mem = 1'b0;

    // flush together with stall_wb still gives a bubble.
    drive(1'b1, 1'b1, 5'd8, 32'h22222222, 3'b000, 2'd0); step();
    chk_all("pre_flush", 1'b1, 5'd8, 32'h22222222, 1'b0, 32'd14);
    flush = 1'b1; stall_wb = 1'b1; step();
    chk_all("flush", 1'b0, 5'd0, 32'd0, 1'b0, 32'd14);
    flush = 1'b0; stall_wb = 1'b0;

    // An input with mem_valid=0 gives a bubble.
    drive(1'b0, 1'b1, 5'd8, 32'h66666666, 3'b000, 2'd0); step();
    chk_all("invalid", 1'b0, 5'd0, 32'd0, 1'b0, 32'd14);

    // A write to r0 retires but does not write.
    drive(1'b1, 1'b1, 5'd0, 32'hDEADBEEF, 3'b000, 2'd0); step();
    chk_all("r0", 1'b0, 5'd0, 32'hDEADBEEF, 1'b0, 32'd15);

    // Counter wrap: preset the count to all-ones, then do one valid capture.
    drive(1'b1, 1'b1, 5'd10, 32'h77777777, 3'b000, 2'd0);
    force dut.cnt_q = 32'hFFFFFFFF;
    #2;
    release dut.cnt_q;
    step();
    chk_all("wrap", 1'b1, 5'd10, 32'h77777777, 1'b0, 32'd0);

    // Reset asserted during a stall discards the held instruction.
    drive(1'b1, 1'b1, 5'd11, 32'h88888888, 3'b000, 2'd0); step();
    chk_all("pre_rst", 1'b1, 5'd11, 32'h88888888, 1'b0, 32'd1);
    stall_wb = 1'b1; step();
    rst = 1'b0; step();
    chk_all("rst_stall", 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);

    // Capture resumes at the first edge after reset is released.
    rst = 1'b1; stall_wb = 1'b0;
    drive(1'b1, 1'b1, 5'd12, 32'h99999999, 3'b000, 2'd0); step();
    chk_all("post_rst", 1'b1, 5'd12, 32'h99999999, 1'b0, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
